accum_master_arbiter: RTL and testbench

// - Shares the single master port of the accumulator router among NUM_REQ requesters
//   (e.g. compute engine, readback DMA).
// - Independent round-robin arbitration on the write channel and the read channel.
// - Tracks outstanding reads in an owner FIFO and steers returned rdata/rvalid to the issuing requester.
// - Sits directly upstream of the router's slave command/data port.

---
 rtl/accum_pkg.sv | 35 +++
 rtl/accum_rr_arbiter.sv | 109 ++++++++++
 rtl/accum_master_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_accum_master_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// ============================================================================
// Package     : accum_pkg
// Description : Shared types and default sizing for the accumulator master
//               arbiter: requester index type, per-channel arbiter state
//               encoding and owner-FIFO pointer/count widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accum_pkg;

    // Default configuration of the master arbiter
    localparam int unsigned ACC_NUM_REQ         = 2;
    localparam int unsigned ACC_MAX_OUTSTANDING = 4;

    // Requester index width (at least one bit, even for degenerate sizes)
    localparam int unsigned REQ_IDX_W = (ACC_NUM_REQ > 1) ? $clog2(ACC_NUM_REQ) : 1;
    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    // Per-channel arbitration state, explicit one-bit encoding
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Owner FIFO pointers wrap naturally (depth is a power of two); the
    // count needs one extra bit to represent "full"
    localparam int unsigned OWN_PTR_W = (ACC_MAX_OUTSTANDING > 1) ? $clog2(ACC_MAX_OUTSTANDING) : 1;
    localparam int unsigned OWN_CNT_W = OWN_PTR_W + 1;
    typedef logic [OWN_PTR_W-1:0] own_ptr_t;
    typedef logic [OWN_CNT_W-1:0] own_cnt_t;

endpackage : accum_pkg

`default_nettype wire

// File: rtl/accum_rr_arbiter.sv
// ============================================================================
// Module      : accum_rr_arbiter
// Description : Round-robin arbiter for one channel. In IDLE the grant is
//               the first valid requester at/after the RR pointer (zero
//               latency). If the granted request does not fire, the grant
//               is locked until it does. On fire the pointer moves to
//               grant+1. Optional checks under ACCUM_ARB_ERR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_rr_arbiter
    import accum_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic               fire_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               valid_o
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;

    logic [IDX_W-1:0] w_pick;
    logic             w_any;
    logic [IDX_W:0]   w_sum;

    // Pointer advance with wrap at NUM_REQ (which need not be a power of 2)
    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + IDX_W'(1);
    endfunction

    // Search for the first valid requester starting at the RR pointer
    always_comb begin
        w_any  = 1'b0;
        w_pick = ptr_q;
        w_sum  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_any && req_valid_i[w_sum[IDX_W-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_sum[IDX_W-1:0];
            end
        end
    end

    // A locked grant must not move until its request fires
    assign grant_o = (state_q == ARB_LOCK) ? grant_q : w_pick;
    assign valid_o = (state_q == ARB_LOCK) ? req_valid_i[grant_q] : w_any;

    // IDLE/LOCK next-state, grant capture and pointer update
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_any) begin
                    if (fire_i) begin
                        ptr_d = f_next(w_pick);
                    end else begin
                        state_d = ARB_LOCK;
                        grant_d = w_pick;
                    end
                end
            end
            ARB_LOCK: begin
                if (fire_i) begin
                    state_d = ARB_IDLE;
                    ptr_d   = f_next(grant_q);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers, cleared to IDLE with the pointer at requester 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ACCUM_ARB_ERR_CHECK_EN
`ifndef SYNTHESIS
    // A requester holding a locked grant must keep its valid up until fire
    a_no_withdraw : assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_LOCK) |-> req_valid_i[grant_q]);
`endif
`endif

endmodule : accum_rr_arbiter

`default_nettype wire

// File: rtl/accum_master_arbiter.sv
// ============================================================================
// Module      : accum_master_arbiter
// Description : Shares the router master port among NUM_REQ requesters with
//               independent round-robin write and read arbitration. An
//               inline owner FIFO records which requester issued each read
//               and steers returning rdata/rvalid back to it.
//               Build option ACCUM_ARB_ERR_CHECK_EN: enables the sticky
//               err_rvalid flag and simulation assertions; undefined ties
//               err_rvalid to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_master_arbiter
    import accum_pkg::*;
#(
    parameter int unsigned NUM_REQ         = ACC_NUM_REQ,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned ZONE_WIDTH      = 2,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned MAX_OUTSTANDING = ACC_MAX_OUTSTANDING
) (
    input  logic                                           clk,
    input  logic                                           rst,
    // requester write side
    input  logic [NUM_REQ-1:0]                             r_wr_valid,
    output logic [NUM_REQ-1:0]                             r_wr_ready,
    input  logic [NUM_REQ-1:0][ZONE_WIDTH-1:0]             r_wr_zone_id,
    input  logic [NUM_REQ-1:0]                             r_accum_en,
    input  logic [NUM_REQ-1:0][NUM_BANKS-1:0]              r_wr_mask,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]             r_wr_addr,
    input  logic [NUM_REQ-1:0][NUM_BANKS*DATA_WIDTH-1:0]   r_wdata,
    // requester read side
    input  logic [NUM_REQ-1:0]                             r_rd_valid,
    output logic [NUM_REQ-1:0]                             r_rd_ready,
    input  logic [NUM_REQ-1:0][ZONE_WIDTH-1:0]             r_rd_zone_id,
    input  logic [NUM_REQ-1:0][NUM_BANKS-1:0]              r_rd_mask,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]             r_rd_addr,
    output logic [NUM_REQ-1:0]                             r_rvalid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]                r_rdata,
    // router write port
    output logic                                           m_wr_valid,
    output logic                                           m_wvalid,
    input  logic                                           m_wr_ready,
    input  logic                                           m_wready,
    output logic [ZONE_WIDTH-1:0]                          m_wr_zone_id,
    output logic                                           m_accum_en,
    output logic [NUM_BANKS-1:0]                           m_wr_mask,
    output logic [ADDR_WIDTH-1:0]                          m_wr_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]                m_wdata,
    // router read port
    output logic                                           m_rd_valid,
    input  logic                                           m_rd_ready,
    output logic [ZONE_WIDTH-1:0]                          m_rd_zone_id,
    output logic [NUM_BANKS-1:0]                           m_rd_mask,
    output logic [ADDR_WIDTH-1:0]                          m_rd_addr,
    input  logic                                           m_rvalid,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]                m_rdata,
    // status
    output logic                                           err_rvalid
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_wr_grant;
    logic             w_wr_arb_valid;
    logic             w_wr_fire;

    accum_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_wr_arb (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (r_wr_valid),
        .fire_i      (w_wr_fire),
        .grant_o     (w_wr_grant),
        .valid_o     (w_wr_arb_valid)
    );

    // The arbiter grants combinationally, so hold the port quiet in reset
    assign m_wr_valid   = w_wr_arb_valid & ~rst;
    assign m_wvalid     = m_wr_valid;
    assign w_wr_fire    = m_wr_valid & m_wr_ready & m_wready;

    assign m_wr_zone_id = r_wr_zone_id[w_wr_grant];
    assign m_accum_en   = r_accum_en[w_wr_grant];
    assign m_wr_mask    = r_wr_mask[w_wr_grant];
    assign m_wr_addr    = r_wr_addr[w_wr_grant];
    assign m_wdata      = r_wdata[w_wr_grant];

    // Acknowledge only the requester whose write fired
    always_comb begin
        r_wr_ready = '0;
        if (w_wr_fire) begin
            r_wr_ready[w_wr_grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_rd_grant;
    logic             w_rd_arb_valid;
    logic             w_rd_fire;
    logic [NUM_REQ-1:0] w_rd_req;

    logic [IDX_W-1:0] owner_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (cnt_q == '0);

    // Hide requests from the arbiter when no owner slot is free, so a full
    // FIFO never leaves the read channel locked on a request it cannot send
    assign w_rd_req = r_rd_valid & {NUM_REQ{~w_full}};

    accum_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rd_arb (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (w_rd_req),
        .fire_i      (w_rd_fire),
        .grant_o     (w_rd_grant),
        .valid_o     (w_rd_arb_valid)
    );

    // Full gating uses the registered count: a same-cycle pop does not help
    assign m_rd_valid   = w_rd_arb_valid & ~w_full & ~rst;
    assign w_rd_fire    = m_rd_valid & m_rd_ready;

    assign m_rd_zone_id = r_rd_zone_id[w_rd_grant];
    assign m_rd_mask    = r_rd_mask[w_rd_grant];
    assign m_rd_addr    = r_rd_addr[w_rd_grant];

    // Acknowledge only the requester whose read fired
    always_comb begin
        r_rd_ready = '0;
        if (w_rd_fire) begin
            r_rd_ready[w_rd_grant] = 1'b1;
        end
    end

    // Returned beats with no recorded owner (incl. the first-push cycle) are dropped
    assign w_push = w_rd_fire;
    assign w_pop  = m_rvalid & ~w_empty;

    // Owner FIFO next-state: pointers wrap by overflow, count tracks occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Owner FIFO control registers; reset forgets all in-flight reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Owner storage holds payload only and is qualified by the count
    always_ff @(posedge clk) begin
        if (w_push) begin
            owner_q[wr_ptr_q] <= w_rd_grant;
        end
    end

    // Steer the returning beat to the requester at the FIFO head
    always_comb begin
        r_rvalid = '0;
        if (w_pop) begin
            r_rvalid[owner_q[rd_ptr_q]] = 1'b1;
        end
    end

    assign r_rdata = m_rdata;

    // ------------------------------------------------------------------
    // Error reporting
    // ------------------------------------------------------------------
`ifdef ACCUM_ARB_ERR_CHECK_EN
    logic err_q;

    // Sticky flag for a returned beat that had no outstanding read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (m_rvalid && w_empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_rvalid = err_q;

`ifndef SYNTHESIS
    // Issue gating must never allow a push into a full owner FIFO
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full));
`endif
`else
    assign err_rvalid = 1'b0;
`endif

endmodule : accum_master_arbiter

`default_nettype wire

// File: tb/tb_accum_master_arbiter.sv
// ============================================================================
// Module      : tb_accum_master_arbiter
// Description : Directed scoreboard bench for accum_master_arbiter. Stimulus
//               pushes expected write/read issues and read returns into
//               queues; a monitor pops and compares whenever the DUT fires
//               or returns data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_master_arbiter;

    localparam int NR = 2;
    localparam int NB = 4;
    localparam int DW = 64;
    localparam int ZW = 2;
    localparam int AW = 8;
    localparam int MO = 4;
    localparam int W  = NB * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NR-1:0]         r_wr_valid = '0;
    logic [NR-1:0]         r_wr_ready;
    logic [NR-1:0][ZW-1:0] r_wr_zone_id = '0;
    logic [NR-1:0]         r_accum_en = '0;
    logic [NR-1:0][NB-1:0] r_wr_mask = '0;
    logic [NR-1:0][AW-1:0] r_wr_addr = '0;
    logic [NR-1:0][W-1:0]  r_wdata = '0;
    logic [NR-1:0]         r_rd_valid = '0;
    logic [NR-1:0]         r_rd_ready;
    logic [NR-1:0][ZW-1:0] r_rd_zone_id = '0;
    logic [NR-1:0][NB-1:0] r_rd_mask = '0;
    logic [NR-1:0][AW-1:0] r_rd_addr = '0;
    logic [NR-1:0]         r_rvalid;
    logic [W-1:0]          r_rdata;
    logic                  m_wr_valid, m_wvalid;
    logic                  m_wr_ready = 1'b0;
    logic                  m_wready = 1'b0;
    logic [ZW-1:0]         m_wr_zone_id;
    logic                  m_accum_en;
    logic [NB-1:0]         m_wr_mask;
    logic [AW-1:0]         m_wr_addr;
    logic [W-1:0]          m_wdata;
    logic                  m_rd_valid;
    logic                  m_rd_ready = 1'b0;
    logic [ZW-1:0]         m_rd_zone_id;
    logic [NB-1:0]         m_rd_mask;
    logic [AW-1:0]         m_rd_addr;
    logic                  m_rvalid = 1'b0;
    logic [W-1:0]          m_rdata = '0;
    logic                  err_rvalid;

    accum_master_arbiter #(
        .NUM_REQ(NR), .NUM_BANKS(NB), .DATA_WIDTH(DW),
        .ZONE_WIDTH(ZW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .r_wr_valid(r_wr_valid), .r_wr_ready(r_wr_ready), .r_wr_zone_id(r_wr_zone_id),
        .r_accum_en(r_accum_en), .r_wr_mask(r_wr_mask), .r_wr_addr(r_wr_addr), .r_wdata(r_wdata),
        .r_rd_valid(r_rd_valid), .r_rd_ready(r_rd_ready), .r_rd_zone_id(r_rd_zone_id),
        .r_rd_mask(r_rd_mask), .r_rd_addr(r_rd_addr), .r_rvalid(r_rvalid), .r_rdata(r_rdata),
        .m_wr_valid(m_wr_valid), .m_wvalid(m_wvalid), .m_wr_ready(m_wr_ready), .m_wready(m_wready),
        .m_wr_zone_id(m_wr_zone_id), .m_accum_en(m_accum_en), .m_wr_mask(m_wr_mask),
        .m_wr_addr(m_wr_addr), .m_wdata(m_wdata),
        .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_zone_id(m_rd_zone_id),
        .m_rd_mask(m_rd_mask), .m_rd_addr(m_rd_addr), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .err_rvalid(err_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0] onehot;
        logic [AW-1:0] addr;
    } req_exp_t;

    typedef struct packed {
        logic [NR-1:0] onehot;
        logic [W-1:0]  data;
    } ret_exp_t;

    req_exp_t wr_q[$];
    req_exp_t rd_q[$];
    ret_exp_t rv_q[$];

    int n_pass  = 0;
    int n_total = 0;

`ifdef ACCUM_ARB_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] wdata_of(input logic [AW-1:0] a);
        return {NB{64'hD000 + 64'(a)}};
    endfunction

    task automatic set_wr(input int g, input logic [AW-1:0] a);
        r_wr_addr[g]    = a;
        r_wdata[g]      = wdata_of(a);
        r_wr_zone_id[g] = ZW'(g);
        r_wr_mask[g]    = 4'hF;
        r_accum_en[g]   = 1'b1;
    endtask

    task automatic set_rd(input int g, input logic [AW-1:0] a);
        r_rd_addr[g]    = a;
        r_rd_zone_id[g] = ZW'(g);
        r_rd_mask[g]    = 4'hF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every fire/return against the head of its queue
    initial begin
        req_exp_t e;
        ret_exp_t r;
        forever begin
            @(negedge clk);
            if (m_wr_valid && m_wr_ready && m_wready) begin
                if (wr_q.size() == 0) chk("wr_unexpected", W'(r_wr_ready), '0);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_grant", W'(r_wr_ready), W'(e.onehot));
                    chk("wr_addr",  W'(m_wr_addr),  W'(e.addr));
                    chk("wr_data",  m_wdata,        wdata_of(e.addr));
                    chk("wvalid_mirror", W'(m_wvalid), W'(1));
                end
            end
            if (m_rd_valid && m_rd_ready) begin
                if (rd_q.size() == 0) chk("rd_unexpected", W'(r_rd_ready), '0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_grant", W'(r_rd_ready), W'(e.onehot));
                    chk("rd_addr",  W'(m_rd_addr),  W'(e.addr));
                end
            end
            if (r_rvalid != '0) begin
                if (rv_q.size() == 0) chk("rvalid_unexpected", W'(r_rvalid), '0);
                else begin
                    r = rv_q.pop_front();
                    chk("rvalid_owner", W'(r_rvalid), W'(r.onehot));
                    chk("rdata",        r_rdata,      r.data);
                end
            end
        end
    end

    // Time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int own[4] = '{0, 1, 1, 0};

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            W'({m_wr_valid, m_wvalid, m_rd_valid, r_wr_ready, r_rd_ready, r_rvalid, err_rvalid}), '0);
        rst = 1'b0;

        // 1: both writers hold valid -> grants alternate 0,1,0,1
        tick();
        set_wr(0, 8'h10);
        set_wr(1, 8'h21);
        m_wr_ready = 1'b1;
        m_wready   = 1'b1;
        r_wr_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wr_q.push_back((i % 2 == 0) ? req_exp_t'{2'b01, 8'h10} : req_exp_t'{2'b10, 8'h21});
        end
        repeat (4) @(posedge clk);
        #1;
        r_wr_valid = '0;

        // 2: data-side stall locks grant 0 while requester 1 waits
        set_wr(0, 8'h30);
        r_wr_valid = 2'b01;
        m_wready   = 1'b0;
        @(negedge clk);
        chk("stall_valid", W'(m_wr_valid), W'(1));
        chk("stall_addr1", W'(m_wr_addr), W'(8'h30));
        chk("stall_noack", W'(r_wr_ready), '0);
        tick();
        set_wr(1, 8'h41);
        r_wr_valid = 2'b11;
        @(negedge clk);
        chk("stall_addr2", W'(m_wr_addr), W'(8'h30));
        chk("stall_zone2", W'(m_wr_zone_id), W'(0));
        tick();
        @(negedge clk);
        chk("stall_addr3", W'(m_wr_addr), W'(8'h30));
        tick();
        m_wready = 1'b1;
        wr_q.push_back('{2'b01, 8'h30});
        tick();
        r_wr_valid = 2'b10;
        wr_q.push_back('{2'b10, 8'h41});
        tick();
        r_wr_valid = '0;

        // 3: requester 1 fills the owner FIFO, then a return frees a slot
        m_rd_ready = 1'b1;
        r_rd_valid = 2'b10;
        for (int i = 0; i < MO; i++) begin
            set_rd(1, AW'(8'h50 + i));
            rd_q.push_back('{2'b10, AW'(8'h50 + i)});
            tick();
        end
        set_rd(1, 8'h54);
        @(negedge clk);
        chk("rd_full_gated", W'(m_rd_valid), '0);
        chk("rd_full_noack", W'(r_rd_ready), '0);
        tick();
        m_rvalid = 1'b1;
        m_rdata  = W'(16'h1111);
        rv_q.push_back('{2'b10, W'(16'h1111)});
        @(negedge clk);
        chk("rd_gated_on_pop", W'(m_rd_valid), '0);
        tick();
        m_rvalid = 1'b0;
        rd_q.push_back('{2'b10, 8'h54});
        @(negedge clk);
        chk("rd_reopen", W'(m_rd_valid), W'(1));
        tick();
        r_rd_valid = '0;
        for (int i = 0; i < MO; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = W'(16'h2000 + i);
            rv_q.push_back('{2'b10, W'(16'h2000 + i)});
            tick();
        end
        m_rvalid = 1'b0;

        // 4: reads from 0,1,1,0 are returned to the same owners in order
        for (int i = 0; i < 4; i++) begin
            r_rd_valid = NR'(1 << own[i]);
            set_rd(own[i], AW'(8'h60 + i));
            rd_q.push_back('{NR'(1 << own[i]), AW'(8'h60 + i)});
            tick();
        end
        r_rd_valid = '0;
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = W'(4'hA + i);
            rv_q.push_back('{NR'(1 << own[i]), W'(4'hA + i)});
            tick();
        end
        m_rvalid = 1'b0;

        // 5: return with nothing outstanding is dropped
        m_rvalid = 1'b1;
        m_rdata  = W'(8'hEE);
        @(negedge clk);
        chk("empty_drop", W'(r_rvalid), '0);
        tick();
        m_rvalid = 1'b0;
        @(negedge clk);
        chk("err_rvalid", W'(err_rvalid), W'(EXP_ERR));

        // 6: reset with two reads in flight and write locked on requester 0
        tick();
        r_rd_valid = 2'b01;
        set_rd(0, 8'h70);
        rd_q.push_back('{2'b01, 8'h70});
        tick();
        set_rd(0, 8'h71);
        rd_q.push_back('{2'b01, 8'h71});
        tick();
        r_rd_valid = '0;
        set_wr(0, 8'h80);
        r_wr_valid = 2'b01;
        m_wready   = 1'b0;
        tick();
        @(negedge clk);
        chk("lock_before_rst", W'(m_wr_valid), W'(1));
        tick();
        rst = 1'b1;
        #1;
        chk("rst_outputs",
            W'({m_wr_valid, m_wvalid, m_rd_valid, r_wr_ready, r_rd_ready, r_rvalid}), '0);
        tick();
        rst        = 1'b0;
        r_wr_valid = '0;
        m_rvalid   = 1'b1;
        m_rdata    = W'(8'h99);
        @(negedge clk);
        chk("late_rvalid_drop", W'(r_rvalid), '0);
        tick();
        m_rvalid   = 1'b0;
        m_wready   = 1'b1;
        set_wr(0, 8'h90);
        set_wr(1, 8'h91);
        set_rd(0, 8'hA0);
        set_rd(1, 8'hA1);
        r_wr_valid = 2'b11;
        r_rd_valid = 2'b11;
        wr_q.push_back('{2'b01, 8'h90});
        rd_q.push_back('{2'b01, 8'hA0});
        tick();
        r_wr_valid = '0;
        r_rd_valid = '0;

        repeat (3) tick();
        chk("wr_q_drained", W'(wr_q.size()), '0);
        chk("rd_q_drained", W'(rd_q.size()), '0);
        chk("rv_q_drained", W'(rv_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_accum_master_arbiter

`default_nettype wire
